mclr5_lsu_bridge: RTL
=====================

Name: mclr5_lsu_bridge

Overview:
- Load/store bridge directly downstream of the quad-issue core's single memory port (LOAD_STORE_ADDRESS, STORE_DATA, LOAD_REQ, STORE_REQ, LOAD_DATA).
- Captures one core request, runs it on an external req/ack data bus, and holds the returned load word stable for the core's writeback.
- Bounds every transaction with a timeout and flags responses that miss the core's fixed load window.

Parameters:
- TIMEOUT, 16, cycles after acceptance with no BUS_ACK before the transaction is aborted (>= 2).
- LOAD_WINDOW, 3, latest acceptance-relative cycle at which the ACK still meets the core's writeback slot.
- ERR_DATA, 32'hDEAD_BEEF, value returned on LOAD_DATA for a timed-out load.

Ports:
- CORE_CLK  input  1  core clock; all state changes on the rising edge.
- RST  input  1  reset; asynchronous, active-high.
- LOAD_STORE_ADDRESS  input  32  core byte address.
- STORE_DATA  input  32  core store word.
- LOAD_REQ  input  1  core load request (single-cycle level).
- STORE_REQ  input  1  core store request (single-cycle level).
- LOAD_DATA  output  32  registered load result to the core.
- BUSY  output  1  high while a transaction is outstanding.
- BUS_REQ  output  1  external bus request.
- BUS_WE  output  1  1 = write, 0 = read.
- BUS_ADDR  output  32  external bus address.
- BUS_WDATA  output  32  external bus write data.
- BUS_ACK  input  1  external completion strobe.
- BUS_RDATA  input  32  external read data; valid when BUS_ACK = 1.
- ERR_CLR  input  1  clears all sticky error flags.
- ERR_TIMEOUT  output  1  sticky; a transaction timed out.
- ERR_LATE  output  1  sticky; an ACK arrived after LOAD_WINDOW.
- ERR_OVERRUN  output  1  sticky; a request arrived while BUSY.

Behaviour:
- Reset (RST high, any time, including mid-transaction): state IDLE. Every output goes to 0: LOAD_DATA, BUSY, BUS_REQ, BUS_WE, BUS_ADDR, BUS_WDATA and all error flags. The cycle counter clears. Any in-flight transaction is abandoned without completion.
- States: IDLE, WAIT. All outputs are registered.
- IDLE:
  - On an edge with LOAD_REQ or STORE_REQ high, latch address and store data into BUS_ADDR and BUS_WDATA.
  - Set BUS_WE = STORE_REQ; if both requests are high, it is a store.
  - Set BUS_REQ = 1 and BUSY = 1, clear the counter to 1, go to WAIT.
  - BUS_ACK in IDLE is ignored.
- WAIT:
  - BUS_REQ, BUS_WE, BUS_ADDR and BUS_WDATA are held stable.
  - The counter increments each edge, saturating at TIMEOUT.
- Completion: on an edge with BUS_ACK = 1 in WAIT:
  - Load: LOAD_DATA <= BUS_RDATA. Store: LOAD_DATA unchanged.
  - BUS_REQ <= 0, BUSY <= 0, go to IDLE.
  - If counter > LOAD_WINDOW at that edge, set ERR_LATE.
- Timeout: on an edge in WAIT with counter == TIMEOUT and BUS_ACK = 0:
  - Load: LOAD_DATA <= ERR_DATA. Store: LOAD_DATA unchanged.
  - BUS_REQ <= 0, BUSY <= 0, set ERR_TIMEOUT, go to IDLE.
  - If ACK and timeout coincide, the ACK wins (normal completion, ERR_LATE rule applies).
- Latency: request sampled at edge 0, BUS_REQ high after edge 0, earliest ACK sampled at edge 1, LOAD_DATA valid after edge 1. LOAD_DATA holds until the next completing load or reset.
- Overrun: LOAD_REQ or STORE_REQ high on any WAIT edge, including the completing edge, is dropped and sets ERR_OVERRUN. A request on the first edge after return to IDLE is accepted, so back-to-back throughput is one transaction per ACK + 1 cycles.
- ERR_CLR: clears all three flags. A set event on the same edge wins over the clear.
- Counter width is $clog2(TIMEOUT+1); it never wraps.

Test Plan:
- Load, ACK one cycle after BUS_REQ: addr 0x0000_0100, BUS_RDATA 0x1234_5678 -> BUS_REQ high for exactly 1 cycle, BUS_WE = 0; LOAD_DATA = 0x1234_5678 two edges after request; no flags set.
- Store to 0x0000_0040, data 0xCAFE_F00D, ACK after 2 cycles -> BUS_WE = 1, BUS_WDATA = 0xCAFE_F00D held until ACK; LOAD_DATA keeps its prior value.
- Load with ACK at counter 5 (LOAD_WINDOW = 3) -> LOAD_DATA = BUS_RDATA, ERR_LATE = 1; ERR_CLR pulse -> ERR_LATE = 0.
- Load with no ACK (TIMEOUT = 16) -> BUS_REQ drops at counter 16, LOAD_DATA = 0xDEAD_BEEF, ERR_TIMEOUT = 1; ACK exactly at counter 16 in a rerun -> normal completion, no timeout.
- Second LOAD_REQ while WAIT -> ignored, single bus transaction, ERR_OVERRUN = 1; request on the first IDLE edge after ACK -> accepted.
- RST asserted mid-WAIT -> BUS_REQ, BUSY and LOAD_DATA go to 0 immediately; after release, a new load completes normally.

Source files
------------

// File: rtl/mclr5_lsu_bridge.sv
// Load/store bridge between the core's single memory port and an external
// req/ack bus. It accepts one request at a time, holds the bus request and
// its address/data stable until ACK or timeout, and keeps the last load
// result stable for the core's writeback. Sticky flags record timeouts,
// late ACKs and requests that arrive while a transaction is outstanding.
//
// Handshake: a core request (LOAD_REQ/STORE_REQ) is taken only on an edge
// in IDLE. BUS_REQ stays high with BUS_WE/BUS_ADDR/BUS_WDATA frozen until
// an edge samples BUS_ACK=1 (completion) or the timeout fires. BUS_RDATA is
// sampled only on an edge where BUS_ACK=1. BUS_ACK is ignored in IDLE.
module mclr5_lsu_bridge #(
  parameter int          TIMEOUT     = 16,
  parameter int          LOAD_WINDOW = 3,
  parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF
) (
  input  logic        CORE_CLK,
  input  logic        RST,
  input  logic [31:0] LOAD_STORE_ADDRESS,
  input  logic [31:0] STORE_DATA,
  input  logic        LOAD_REQ,
  input  logic        STORE_REQ,
  output logic [31:0] LOAD_DATA,
  output logic        BUSY,
  output logic        BUS_REQ,
  output logic        BUS_WE,
  output logic [31:0] BUS_ADDR,
  output logic [31:0] BUS_WDATA,
  input  logic        BUS_ACK,
  input  logic [31:0] BUS_RDATA,
  input  logic        ERR_CLR,
  output logic        ERR_TIMEOUT,
  output logic        ERR_LATE,
  output logic        ERR_OVERRUN
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_WIN = CW'(LOAD_WINDOW);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  logic [0:0]    state;
  logic [CW-1:0] cnt;

  // Event strobes feeding the sticky flags; all decoded from current state.
  logic any_req;
  logic in_wait;
  logic done_ack;
  logic done_tmo;
  logic set_late;
  logic set_overrun;

  // Decode completion/timeout/overrun events for this edge.
  always_comb begin
    any_req     = LOAD_REQ | STORE_REQ;
    in_wait     = (state == S_WAIT);
    done_ack    = in_wait & BUS_ACK;
    // ACK takes priority when it lands on the timeout cycle.
    done_tmo    = in_wait & ~BUS_ACK & (cnt == CNT_MAX);
    set_late    = done_ack & (cnt > CNT_WIN);
    set_overrun = in_wait & any_req;
  end

  // Transaction FSM, bus outputs, cycle counter and load result register.
  always_ff @(posedge CORE_CLK or posedge RST) begin
    if (RST) begin
      state     <= S_IDLE;
      cnt       <= '0;
      BUSY      <= 1'b0;
      BUS_REQ   <= 1'b0;
      BUS_WE    <= 1'b0;
      BUS_ADDR  <= '0;
      BUS_WDATA <= '0;
      LOAD_DATA <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_req) begin
            BUS_ADDR  <= LOAD_STORE_ADDRESS;
            BUS_WDATA <= STORE_DATA;
            // A simultaneous load+store is treated as a store.
            BUS_WE    <= STORE_REQ;
            BUS_REQ   <= 1'b1;
            BUSY      <= 1'b1;
            cnt       <= CNT_ONE;
            state     <= S_WAIT;
          end
        end
        default: begin
          if (done_ack) begin
            if (!BUS_WE) LOAD_DATA <= BUS_RDATA;
            BUS_REQ <= 1'b0;
            BUSY    <= 1'b0;
            state   <= S_IDLE;
          end else if (done_tmo) begin
            if (!BUS_WE) LOAD_DATA <= ERR_DATA;
            BUS_REQ <= 1'b0;
            BUSY    <= 1'b0;
            state   <= S_IDLE;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CNT_ONE;
          end
        end
      endcase
    end
  end

  // Sticky error flags; a set on the same edge as ERR_CLR wins.
  always_ff @(posedge CORE_CLK or posedge RST) begin
    if (RST) begin
      ERR_TIMEOUT <= 1'b0;
      ERR_LATE    <= 1'b0;
      ERR_OVERRUN <= 1'b0;
    end else begin
      ERR_TIMEOUT <= (ERR_TIMEOUT & ~ERR_CLR) | done_tmo;
      ERR_LATE    <= (ERR_LATE    & ~ERR_CLR) | set_late;
      ERR_OVERRUN <= (ERR_OVERRUN & ~ERR_CLR) | set_overrun;
    end
  end

endmodule
